// File: rtl/wb_regfile_hilo.sv
// wb_regfile_hilo: write-back sink holding the 32x32 GPR file ($0 fixed at zero) and the HI/LO pair.
//   clk                              rising-edge clock
//   rst                              asynchronous active-low reset
//   wb_wd/wb_wreg/wb_wdata           GPR write port from MEM/WB
//   wb_whilo/wb_hi/wb_lo             HI/LO write port (both halves together)
//   re1/raddr1/rdata1                GPR read port 1, combinational with write bypass
//   re2/raddr2/rdata2                GPR read port 2, combinational with write bypass
//   hi_o/lo_o                        HI/LO read port, combinational with write bypass
module wb_regfile_hilo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_gpr_we;

    // $0 is never written, so it stays at its reset value of zero.
    assign w_gpr_we = wb_wreg && (wb_wd != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_gpr_we) r_regs[wb_wd] <= wb_wdata;
            if (wb_whilo) begin
                r_hi <= wb_hi;
                r_lo <= wb_lo;
            end
        end
    end

    // Bypass only when the write would actually land; $0 is masked before the bypass.
    assign rdata1 = (!rst || !re1 || raddr1 == '0) ? '0 :
                    (wb_wreg && wb_wd == raddr1)   ? wb_wdata : r_regs[raddr1];
    assign rdata2 = (!rst || !re2 || raddr2 == '0) ? '0 :
                    (wb_wreg && wb_wd == raddr2)   ? wb_wdata : r_regs[raddr2];
    assign hi_o   = !rst ? '0 : wb_whilo ? wb_hi : r_hi;
    assign lo_o   = !rst ? '0 : wb_whilo ? wb_lo : r_lo;
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// tb_wb_regfile_hilo: directed bench for wb_regfile_hilo with a reference model checked every cycle.
module tb_wb_regfile_hilo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  wb_wd = '0;
    logic        wb_wreg = 1'b0;
    logic [31:0] wb_wdata = '0;
    logic        wb_whilo = 1'b0;
    logic [31:0] wb_hi = '0;
    logic [31:0] wb_lo = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_reg [32] = '{default: 32'h0};
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    wb_regfile_hilo dut (
        .clk(clk), .rst(rst),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Architectural state: reset wipes everything, a clock edge commits whatever MEM/WB presents.
    always @(negedge rst) begin
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_hi = '0;
        m_lo = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (wb_wreg && wb_wd != 0) m_reg[wb_wd] = wb_wdata;
            if (wb_whilo) begin
                m_hi = wb_hi;
                m_lo = wb_lo;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
        if (!rst || !en || a == 0) return 32'h0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_reg[a];
    endfunction

    always @(negedge clk) begin
        chk("cyc_rdata1", rdata1, exp_rd(re1, raddr1));
        chk("cyc_rdata2", rdata2, exp_rd(re2, raddr2));
        chk("cyc_hi", hi_o, !rst ? 32'h0 : wb_whilo ? wb_hi : m_hi);
        chk("cyc_lo", lo_o, !rst ? 32'h0 : wb_whilo ? wb_lo : m_lo);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return (i * 32'h01010101) ^ 32'hC000_0000;
    endfunction

    initial begin
        // Reset held, with writes presented that must be ignored
        re1 = 1; re2 = 1; raddr1 = 5; raddr2 = 31;
        wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hFFFF_FFFF;
        wb_whilo = 1; wb_hi = 32'h1111_1111; wb_lo = 32'h2222_2222;
        #1;
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        step();
        step();
        wb_wreg = 0; wb_whilo = 0; rst = 1;
        #1;
        chk("post_rst_rd1", rdata1, 32'h0);
        chk("post_rst_rd2", rdata2, 32'h0);
        chk("post_rst_hi", hi_o, 32'h0);
        chk("post_rst_lo", lo_o, 32'h0);
        // Write then read
        step();
        wb_wreg = 1; wb_wd = 7; wb_wdata = 32'hDEAD_BEEF;
        step();
        wb_wd = 31; wb_wdata = 32'h1234_5678;
        step();
        wb_wreg = 0; raddr1 = 7; raddr2 = 31;
        #1;
        chk("rd_r7", rdata1, 32'hDEAD_BEEF);
        chk("rd_r31", rdata2, 32'h1234_5678);
        re1 = 0;
        #1;
        chk("re1_off", rdata1, 32'h0);
        re1 = 1;
        // Bypass and $0
        step();
        wb_wreg = 1; wb_wd = 9; wb_wdata = 32'hA5A5_A5A5; raddr1 = 9; raddr2 = 9;
        #1;
        chk("byp_rd1", rdata1, 32'hA5A5_A5A5);
        chk("byp_rd2", rdata2, 32'hA5A5_A5A5);
        step();
        wb_wd = 0; wb_wdata = 32'hFFFF_FFFF; raddr1 = 0;
        #1;
        chk("r0_same", rdata1, 32'h0);
        step();
        wb_wreg = 0;
        #1;
        chk("r0_next", rdata1, 32'h0);
        chk("r9_held", rdata2, 32'hA5A5_A5A5);
        // HI/LO with a simultaneous GPR write
        step();
        wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
        wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h33; raddr1 = 3;
        #1;
        chk("hilo_byp_hi", hi_o, 32'h1);
        chk("hilo_byp_lo", lo_o, 32'h2);
        chk("r3_byp", rdata1, 32'h33);
        step();
        wb_whilo = 0; wb_wreg = 0;
        #1;
        chk("hilo_held_hi", hi_o, 32'h1);
        chk("hilo_held_lo", lo_o, 32'h2);
        chk("r3_held", rdata1, 32'h33);
        // Bubble carrying junk data
        step();
        wb_wd = 3; wb_wdata = 32'hDEAD_0000; wb_hi = 32'h77; wb_lo = 32'h88;
        step();
        #1;
        chk("bubble_hi", hi_o, 32'h1);
        chk("bubble_lo", lo_o, 32'h2);
        chk("bubble_r3", rdata1, 32'h33);
        // Fill every register and HI/LO
        for (int i = 1; i < 32; i++) begin
            step();
            wb_wreg = 1; wb_wd = 5'(i); wb_wdata = fill_val(i);
        end
        step();
        wb_wreg = 0; wb_whilo = 1; wb_hi = 32'hAAAA_AAAA; wb_lo = 32'h5555_5555;
        step();
        wb_whilo = 0;
        for (int i = 1; i < 32; i++) begin
            step();
            raddr1 = 5'(i); raddr2 = 5'(32 - i);
            #1;
            chk("fill_rd1", rdata1, fill_val(i));
            chk("fill_rd2", rdata2, fill_val(32 - i));
        end
        chk("fill_hi", hi_o, 32'hAAAA_AAAA);
        chk("fill_lo", lo_o, 32'h5555_5555);
        // Asynchronous reset pulse between edges, with a write asserted while low
        raddr1 = 31; raddr2 = 4;
        @(posedge clk);
        #2;
        rst = 0; wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h0000_0BAD;
        #1;
        chk("pulse_rd1", rdata1, 32'h0);
        chk("pulse_rd2", rdata2, 32'h0);
        chk("pulse_hi", hi_o, 32'h0);
        chk("pulse_lo", lo_o, 32'h0);
        @(posedge clk);
        #2;
        rst = 1; wb_wreg = 0;
        #1;
        chk("pulse_r4", rdata2, 32'h0);
        chk("pulse_after_hi", hi_o, 32'h0);
        chk("pulse_after_lo", lo_o, 32'h0);
        for (int i = 0; i < 32; i++) begin
            step();
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            chk("clr_rd1", rdata1, 32'h0);
            chk("clr_rd2", rdata2, 32'h0);
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_regfile_hilo.md
Name: wb_regfile_hilo

Overview:
- Write-back sink of the pipeline: consumes the MEM/WB register outputs and commits them to architectural state.
- Holds the 32x32 general-purpose register file ($0 hardwired to zero) plus the HI/LO pair.
- Exposes two combinational GPR read ports for ID and one HI/LO read port for EX.
- Same-cycle write-before-read bypass on every read port, so a WB-stage value is visible to the reader in the same cycle it is written.

Parameters:
- DATA_W, 32, width of GPR, HI and LO.
- ADDR_W, 5, GPR address width.
- NREG, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wb_wd  in  ADDR_W  GPR write address from MEM/WB.
- wb_wreg  in  1  GPR write enable (1 = write).
- wb_wdata  in  DATA_W  GPR write data.
- wb_whilo  in  1  HI/LO write enable (1 = write both).
- wb_hi  in  DATA_W  HI write data.
- wb_lo  in  DATA_W  LO write data.
- re1  in  1  read-port-1 enable.
- raddr1  in  ADDR_W  read-port-1 address.
- rdata1  out  DATA_W  read-port-1 data, combinational.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_W  read-port-2 address.
- rdata2  out  DATA_W  read-port-2 data, combinational.
- hi_o  out  DATA_W  current HI, bypassed.
- lo_o  out  DATA_W  current LO, bypassed.

Behaviour:
- Reset:
  - rst low asynchronously clears all NREG GPRs, HI and LO to 0, with no clock edge needed.
  - While rst is low, rdata1, rdata2, hi_o and lo_o are 0 and all writes are ignored.
  - Deassertion takes effect at the next rising clk; there is no partial state.
- GPR write:
  - At posedge clk, if rst is high, wb_wreg=1 and wb_wd!=0, then reg[wb_wd] <= wb_wdata.
  - A write to address 0 is silently dropped; reg0 reads 0 forever.
  - Write latency: 1 cycle to storage, 0 cycles to readers through the bypass.
- HI/LO write: at posedge clk, if rst is high and wb_whilo=1, then HI <= wb_hi and LO <= wb_lo in the same edge. There is no split write.
- GPR read, port n (n = 1, 2), evaluated combinationally in this priority order:
  1. rst low -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (bypass).
  5. Otherwise -> reg[raddr_n].
- Both ports may read the same address, and may read the address being written, simultaneously. Each applies the rules independently.
- HI/LO read:
  - rst low -> hi_o = lo_o = 0.
  - wb_whilo=1 -> hi_o = wb_hi and lo_o = wb_lo (bypass).
  - Otherwise -> stored HI and LO.
- Independence: a GPR write and a HI/LO write in the same cycle both commit. Neither blocks the other.
- Stall/flush: none handled here. MEM/WB presents bubbles as wreg=0, whilo=0, and those bubbles change no state.
- No X propagation: every output is driven from defined state or inputs in all conditions.

Test Plan:
- Reset value: hold rst=0, then apply re1=re2=1 with raddr1=5, raddr2=31 -> rdata1=rdata2=0 and hi_o=lo_o=0. Release rst, no writes -> all read values still 0.
- Write then read:
  - Write reg7=0xDEADBEEF, reg31=0x12345678.
  - Next cycle, read raddr1=7, raddr2=31 -> 0xDEADBEEF and 0x12345678.
  - Drop re1 -> rdata1=0.
- Bypass and $0:
  - In the same cycle, wb_wreg=1, wb_wd=9, wb_wdata=0xA5A5A5A5, raddr1=raddr2=9 -> both read 0xA5A5A5A5 before the edge.
  - Write wb_wd=0 with data 0xFFFFFFFF, then read raddr1=0 -> 0 both same-cycle and next cycle.
- HI/LO:
  - wb_whilo=1, wb_hi=0x1, wb_lo=0x2 -> hi_o/lo_o = 1/2 in the same cycle, held after wb_whilo=0.
  - A simultaneous GPR write to reg3=0x33 also commits.
  - A bubble cycle (wreg=0, whilo=0) changes nothing.
- Async reset mid-operation:
  - After filling reg1..reg31 and HI/LO, pulse rst low between clock edges -> all outputs go to 0 immediately.
  - A write asserted during the low pulse is not committed.
  - After release, every register reads 0.
